// File: rtl/csi_tx_packetizer.sv
// rtl/csi_tx_packetizer.sv - two-lane CSI-2 transmit packetizer (sync, header+ECC, payload, CRC-16)
module csi_tx_packetizer #(
  parameter int GAP_CYCLES = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        FS_REQ,
  input  logic        FE_REQ,
  input  logic [15:0] FRAME_NUM,
  input  logic        LINE_REQ,
  input  logic [1:0]  VC,
  input  logic [5:0]  DT,
  input  logic [15:0] WC,
  output logic        REQ_READY,
  input  logic        PIX_VALID,
  input  logic [15:0] PIX_DATA,
  output logic        PIX_READY,
  output logic [7:0]  DOUT0,
  output logic [7:0]  DOUT1,
  output logic        DVALID,
  output logic        BUSY,
  output logic        UNDERRUN
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_HDR0, S_HDR1, S_PAYLOAD, S_CRC, S_GAP
  } state_t;

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t      state, state_d;
  logic [7:0]  di_q;
  logic [15:0] wc_q;
  logic        long_q;
  logic [14:0] words_left;
  logic [7:0]  gap_cnt;
  logic [15:0] crc_q;
  logic [5:0]  ecc;
  logic [23:0] d;
  logic [15:0] word_in;
  logic        accept;
  logic [7:0]  lane0_d, lane1_d;
  logic        dvalid_d;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign REQ_READY = (state == S_IDLE);
  assign PIX_READY = (state == S_PAYLOAD);
  assign BUSY      = (state != S_IDLE);
  assign accept    = REQ_READY && (FS_REQ || LINE_REQ || FE_REQ);
  // A starved payload cycle still goes out on the wire, as zeros.
  assign word_in   = PIX_VALID ? PIX_DATA : 16'h0000;

  assign d = {wc_q, di_q};
  assign ecc[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
  assign ecc[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
  assign ecc[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
  assign ecc[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
  assign ecc[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
  assign ecc[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    lane0_d  = 8'h00;
    lane1_d  = 8'h00;
    dvalid_d = 1'b0;
    case (state)
      S_IDLE: if (accept) state_d = S_SYNC;
      S_SYNC: begin
        state_d  = S_HDR0;
        lane0_d  = 8'hB8;
        lane1_d  = 8'hB8;
        dvalid_d = 1'b1;
      end
      S_HDR0: begin
        state_d  = S_HDR1;
        lane0_d  = di_q;
        lane1_d  = wc_q[7:0];
        dvalid_d = 1'b1;
      end
      S_HDR1: begin
        if (!long_q)                 state_d = S_GAP;
        else if (wc_q[15:1] == 15'd0) state_d = S_CRC;
        else                         state_d = S_PAYLOAD;
        lane0_d  = wc_q[15:8];
        lane1_d  = {2'b00, ecc};
        dvalid_d = 1'b1;
      end
      S_PAYLOAD: begin
        if (words_left == 15'd1) state_d = S_CRC;
        lane0_d  = word_in[7:0];
        lane1_d  = word_in[15:8];
        dvalid_d = 1'b1;
      end
      S_CRC: begin
        state_d  = S_GAP;
        lane0_d  = crc_q[7:0];
        lane1_d  = crc_q[15:8];
        dvalid_d = 1'b1;
      end
      S_GAP: if (gap_cnt == GAP_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      di_q   <= 8'h00;
      wc_q   <= 16'h0000;
      long_q <= 1'b0;
    end else if (accept) begin
      if (FS_REQ) begin
        di_q   <= {VC, 6'h00};
        wc_q   <= FRAME_NUM;
        long_q <= 1'b0;
      end else if (LINE_REQ) begin
        di_q   <= {VC, DT};
        wc_q   <= WC & 16'hFFFE;
        long_q <= 1'b1;
      end else begin
        di_q   <= {VC, 6'h01};
        wc_q   <= FRAME_NUM;
        long_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      words_left <= 15'd0;
      gap_cnt    <= 8'd0;
      crc_q      <= 16'hFFFF;
      UNDERRUN   <= 1'b0;
    end else begin
      gap_cnt <= (state == S_GAP) ? gap_cnt + 8'd1 : 8'd0;
      if (state == S_HDR1) begin
        words_left <= wc_q[15:1];
        crc_q      <= 16'hFFFF;
      end else if (state == S_PAYLOAD) begin
        words_left <= words_left - 15'd1;
        crc_q      <= crc16_byte(crc16_byte(crc_q, word_in[7:0]), word_in[15:8]);
        if (!PIX_VALID) UNDERRUN <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      DOUT0  <= 8'h00;
      DOUT1  <= 8'h00;
      DVALID <= 1'b0;
    end else begin
      DOUT0  <= lane0_d;
      DOUT1  <= lane1_d;
      DVALID <= dvalid_d;
    end
  end

endmodule

// File: tb/tb_csi_tx_packetizer.sv
// tb/tb_csi_tx_packetizer.sv - directed self-checking bench for csi_tx_packetizer
module tb_csi_tx_packetizer;
  localparam int G = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FS_REQ = 1'b0, FE_REQ = 1'b0, LINE_REQ = 1'b0;
  logic [15:0] FRAME_NUM = 16'h0;
  logic [1:0]  VC = 2'd0;
  logic [5:0]  DT = 6'd0;
  logic [15:0] WC = 16'h0;
  logic        REQ_READY;
  logic        PIX_VALID = 1'b0;
  logic [15:0] PIX_DATA = 16'h0;
  logic        PIX_READY;
  logic [7:0]  DOUT0, DOUT1;
  logic        DVALID, BUSY, UNDERRUN;

  int total = 0;
  int bad = 0;
  logic [15:0] cap[$];
  logic [15:0] exp_q[$];
  int first_dv, rdy_cycle, pix_first, pix_cnt;
  logic hit_rst;

  csi_tx_packetizer #(.GAP_CYCLES(G)) dut (
    .CLK(CLK), .RST(RST), .FS_REQ(FS_REQ), .FE_REQ(FE_REQ), .FRAME_NUM(FRAME_NUM),
    .LINE_REQ(LINE_REQ), .VC(VC), .DT(DT), .WC(WC), .REQ_READY(REQ_READY),
    .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA), .PIX_READY(PIX_READY),
    .DOUT0(DOUT0), .DOUT1(DOUT1), .DVALID(DVALID), .BUSY(BUSY), .UNDERRUN(UNDERRUN)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] crc_b(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ b[i]) == 1'b1) r = (r >> 1) ^ 16'h8408;
      else                       r = r >> 1;
    end
    return r;
  endfunction

  // Cycle 1 is the cycle after the acceptance edge; captured pairs are {DOUT1, DOUT0}.
  task automatic run_pkt(input logic fs, input logic fe, input logic line,
                         input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                         input logic [15:0] fnum, input int drop, input int hold, input int rst_at);
    int pidx;
    cap.delete();
    first_dv = -1; rdy_cycle = -1; pix_first = -1; pix_cnt = 0; hit_rst = 1'b0;
    FS_REQ = fs; FE_REQ = fe; LINE_REQ = line;
    VC = vc; DT = dt; WC = wc; FRAME_NUM = fnum;
    PIX_VALID = 1'b1; PIX_DATA = 16'h1407;
    @(posedge CLK); #1;
    pidx = 0;
    for (int c = 1; c < 200; c++) begin
      if (c > hold) begin FS_REQ = 1'b0; FE_REQ = 1'b0; LINE_REQ = 1'b0; end
      if (DVALID) begin
        cap.push_back({DOUT1, DOUT0});
        if (first_dv < 0) first_dv = c;
      end
      if (PIX_READY) begin
        if (pix_first < 0) pix_first = c;
        pix_cnt++;
        if (pidx == rst_at) begin
          RST = 1'b1;
          @(posedge CLK); #1;
          RST = 1'b0;
          hit_rst = 1'b1;
          break;
        end
        PIX_VALID = (pidx != drop);
        pidx++;
      end else begin
        PIX_VALID = 1'b1;
      end
      if (REQ_READY) begin rdy_cycle = c; break; end
      @(posedge CLK); #1;
    end
    PIX_VALID = 1'b0;
    FS_REQ = 1'b0; FE_REQ = 1'b0; LINE_REQ = 1'b0;
    if (rdy_cycle < 0 && !hit_rst) begin
      total++; bad++;
      $display("FAIL timeout: REQ_READY never returned within 200 cycles");
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    total++;
    if ({DOUT1, DOUT0, DVALID, BUSY, UNDERRUN, REQ_READY, PIX_READY} !== {16'h0000, 5'b00010}) begin
      bad++;
      $display("FAIL reset_outputs: got dout=%h dv=%b busy=%b ur=%b rr=%b pr=%b want 0000 0 0 0 1 0",
               {DOUT1, DOUT0}, DVALID, BUSY, UNDERRUN, REQ_READY, PIX_READY);
    end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_frame_start;
    run_pkt(1'b1, 1'b0, 1'b0, 2'd0, 6'h00, 16'h0, 16'h0001, -1, 0, -1);
    exp_q = '{16'hB8B8, 16'h0100, 16'h1A00};
    total++;
    if (cap.size() !== 3) begin bad++; $display("FAIL fs_dvalid_len: got %0d want 3", cap.size()); end
    for (int i = 0; i < 3 && i < cap.size(); i++) begin
      total++;
      if (cap[i] !== exp_q[i]) begin bad++; $display("FAIL fs_pair%0d: got %h want %h", i, cap[i], exp_q[i]); end
    end
    total++;
    if (first_dv !== 2) begin bad++; $display("FAIL fs_first_dvalid: got %0d want 2", first_dv); end
    total++;
    if (rdy_cycle !== 4 + G) begin bad++; $display("FAIL fs_req_ready_return: got %0d want %0d", rdy_cycle, 4 + G); end
    total++;
    if (BUSY !== 1'b0) begin bad++; $display("FAIL fs_busy_after_gap: got %b want 0", BUSY); end
  endtask

  task automatic test_frame_end;
    run_pkt(1'b0, 1'b1, 1'b0, 2'd0, 6'h00, 16'h0, 16'h0000, -1, 0, -1);
    exp_q = '{16'hB8B8, 16'h0001, 16'h0700};
    total++;
    if (cap.size() !== 3) begin bad++; $display("FAIL fe_dvalid_len: got %0d want 3", cap.size()); end
    for (int i = 0; i < 3 && i < cap.size(); i++) begin
      total++;
      if (cap[i] !== exp_q[i]) begin bad++; $display("FAIL fe_pair%0d: got %h want %h", i, cap[i], exp_q[i]); end
    end
  endtask

  task automatic test_long_line(input int drop);
    logic [15:0] crc, w;
    run_pkt(1'b0, 1'b0, 1'b1, 2'd1, 6'h2B, 16'h0008, 16'h0, drop, 0, -1);
    exp_q = '{16'hB8B8, 16'h086B, 16'h2400};
    crc = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      w = (i == drop) ? 16'h0000 : 16'h1407;
      exp_q.push_back(w);
      crc = crc_b(crc_b(crc, w[7:0]), w[15:8]);
    end
    exp_q.push_back(crc);
    total++;
    if (cap.size() !== 8) begin bad++; $display("FAIL line_dvalid_len(drop=%0d): got %0d want 8", drop, cap.size()); end
    for (int i = 0; i < 8 && i < cap.size(); i++) begin
      total++;
      if (cap[i] !== exp_q[i]) begin bad++; $display("FAIL line_pair%0d(drop=%0d): got %h want %h", i, drop, cap[i], exp_q[i]); end
    end
    total++;
    if (pix_first !== 4 || pix_cnt !== 4) begin
      bad++; $display("FAIL line_pix_ready: first=%0d count=%0d want first=4 count=4", pix_first, pix_cnt);
    end
    total++;
    if (rdy_cycle !== 9 + G) begin bad++; $display("FAIL line_req_ready_return: got %0d want %0d", rdy_cycle, 9 + G); end
    total++;
    if (UNDERRUN !== (drop >= 0)) begin bad++; $display("FAIL line_underrun(drop=%0d): got %b want %b", drop, UNDERRUN, drop >= 0); end
  endtask

  task automatic test_priority;
    run_pkt(1'b1, 1'b1, 1'b1, 2'd0, 6'h2B, 16'h0008, 16'h0003, -1, 3, -1);
    exp_q = '{16'hB8B8, 16'h0300, 16'h0600};
    total++;
    if (cap.size() !== 3) begin bad++; $display("FAIL prio_dvalid_len: got %0d want 3", cap.size()); end
    for (int i = 0; i < 3 && i < cap.size(); i++) begin
      total++;
      if (cap[i] !== exp_q[i]) begin bad++; $display("FAIL prio_pair%0d: got %h want %h", i, cap[i], exp_q[i]); end
    end
    total++;
    if (UNDERRUN !== 1'b1) begin bad++; $display("FAIL underrun_sticky: got %b want 1", UNDERRUN); end
  endtask

  task automatic test_odd_wc;
    logic [15:0] crc;
    run_pkt(1'b0, 1'b0, 1'b1, 2'd0, 6'h2B, 16'h0005, 16'h0, -1, 0, -1);
    crc = 16'hFFFF;
    for (int i = 0; i < 2; i++) crc = crc_b(crc_b(crc, 8'h07), 8'h14);
    exp_q = '{16'hB8B8, 16'h042B, 16'h3400, 16'h1407, 16'h1407};
    exp_q.push_back(crc);
    total++;
    if (cap.size() !== 6) begin bad++; $display("FAIL wc5_dvalid_len: got %0d want 6", cap.size()); end
    for (int i = 0; i < 6 && i < cap.size(); i++) begin
      total++;
      if (cap[i] !== exp_q[i]) begin bad++; $display("FAIL wc5_pair%0d: got %h want %h", i, cap[i], exp_q[i]); end
    end
    total++;
    if (pix_cnt !== 2) begin bad++; $display("FAIL wc5_payload_cycles: got %0d want 2", pix_cnt); end
  endtask

  task automatic test_empty_line;
    run_pkt(1'b0, 1'b0, 1'b1, 2'd0, 6'h2B, 16'h0001, 16'h0, -1, 0, -1);
    exp_q = '{16'hB8B8, 16'h002B, 16'h1700, 16'hFFFF};
    total++;
    if (cap.size() !== 4) begin bad++; $display("FAIL wc1_dvalid_len: got %0d want 4", cap.size()); end
    for (int i = 0; i < 4 && i < cap.size(); i++) begin
      total++;
      if (cap[i] !== exp_q[i]) begin bad++; $display("FAIL wc1_pair%0d: got %h want %h", i, cap[i], exp_q[i]); end
    end
    total++;
    if (pix_cnt !== 0 || rdy_cycle !== 5 + G) begin
      bad++; $display("FAIL wc1_timing: pix=%0d ready=%0d want pix=0 ready=%0d", pix_cnt, rdy_cycle, 5 + G);
    end
  endtask

  task automatic test_reset_mid_packet;
    run_pkt(1'b0, 1'b0, 1'b1, 2'd1, 6'h2B, 16'h0008, 16'h0, -1, 0, 1);
    total++;
    if (hit_rst !== 1'b1) begin bad++; $display("FAIL rst_mid_reached_payload: got %b want 1", hit_rst); end
    total++;
    if ({DVALID, DOUT1, DOUT0, REQ_READY, BUSY, UNDERRUN} !== {1'b0, 16'h0000, 3'b100}) begin
      bad++;
      $display("FAIL rst_mid_outputs: dv=%b dout=%h rr=%b busy=%b ur=%b want 0 0000 1 0 0",
               DVALID, {DOUT1, DOUT0}, REQ_READY, BUSY, UNDERRUN);
    end
    run_pkt(1'b1, 1'b0, 1'b0, 2'd2, 6'h00, 16'h0, 16'h0003, -1, 0, -1);
    exp_q = '{16'hB8B8, 16'h0380, 16'h1F00};
    total++;
    if (cap.size() !== 3) begin bad++; $display("FAIL post_rst_fs_len: got %0d want 3", cap.size()); end
    for (int i = 0; i < 3 && i < cap.size(); i++) begin
      total++;
      if (cap[i] !== exp_q[i]) begin bad++; $display("FAIL post_rst_fs_pair%0d: got %h want %h", i, cap[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_frame_start();
    test_frame_end();
    test_long_line(-1);
    test_long_line(1);
    test_priority();
    test_odd_wc();
    test_empty_line();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
